// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, programmable almost flags, overflow/underflow pulses; define FIFO_FWFT_EN for first-word-fall-through reads
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_LEVEL);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
  logic              rd_acc, wr_acc;
  // acceptance, next pointers/count, and next read data (FWFT tracks the post-edge head, bypassing a same-cycle write into an empty head slot)
  always_comb begin
    rd_acc   = rd && !empty_q;
    wr_acc   = wr && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_acc);
    count_d  = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
`ifdef FIFO_FWFT_EN
    r_data_d = (count_d == '0) ? r_data_q :
               (wr_acc && rd_ptr_d == wr_ptr_q) ? w_data : mem_q[rd_ptr_d[ADDR_W-1:0]];
`else
    r_data_d = rd_acc ? mem_q[rd_ptr_q[ADDR_W-1:0]] : r_data_q;
`endif
  end
  // storage array, never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= w_data;
  end
  // pointers, count, registered flags, error pulses and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      r_data_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      r_data_q <= r_data_d;
      empty_q  <= count_d == '0;
      full_q   <= count_d[ADDR_W];
      ae_q     <= count_d <= AE_L;
      af_q     <= count_d >= AF_L;
      ovf_q    <= wr && !wr_acc;
      udf_q    <= rd && !rd_acc;
    end
  end
  assign r_data       = r_data_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: vector table plus data scoreboard for fifo_sync_param (default DATA_W=8, ADDR_W=4)
module tb_fifo_sync_param;
  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       emp, ful, ae, af, ovf, udf;
  } vec_t;
  logic       clk = 0;
  logic       reset = 0;
  logic       wr = 0;
  logic       rd = 0;
  logic [7:0] w_data = 0;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_r = 0;
  vec_t       tv[$];
  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic vec_t mk(logic w, logic r, logic [7:0] d, int c, logic o, logic u);
    vec_t v;
    v.wr = w; v.rd = r; v.d = d; v.cnt = 5'(c);
    v.emp = (c == 0); v.ful = (c == 16); v.ae = (c <= 2); v.af = (c >= 14);
    v.ovf = o; v.udf = u;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    logic [7:0] p;
    @(negedge clk);
    wr = v.wr; rd = v.rd; w_data = v.d;
    if (v.rd && !v.udf) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: read expected but model queue empty at %0t", $time);
      end else begin
        p = sb.pop_front();
`ifndef FIFO_FWFT_EN
        exp_r = p;
`endif
      end
    end
    if (v.wr && !v.ovf) sb.push_back(v.d);
`ifdef FIFO_FWFT_EN
    if (sb.size() != 0) exp_r = sb[0];
`endif
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(v.cnt));
    chk("empty", 32'(empty), 32'(v.emp));
    chk("full", 32'(full), 32'(v.ful));
    chk("almost_empty", 32'(almost_empty), 32'(v.ae));
    chk("almost_full", 32'(almost_full), 32'(v.af));
    chk("overflow", 32'(overflow), 32'(v.ovf));
    chk("underflow", 32'(underflow), 32'(v.udf));
    chk("r_data", 32'(r_data), 32'(exp_r));
    wr = 0; rd = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) tv.push_back(mk(1, 0, 8'(i + 1), i + 1, 0, 0));
    tv.push_back(mk(1, 0, 8'hFF, 16, 1, 0));
    for (int i = 0; i < 16; i++) tv.push_back(mk(0, 1, 8'h00, 15 - i, 0, 0));
    tv.push_back(mk(0, 1, 8'h00, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_r_data", 32'(r_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < tv.size(); i++) apply(tv[i]);
    chk("drain_hold", 32'(r_data), 32'h10);
    for (int i = 0; i < 16; i++) apply(mk(1, 0, 8'(8'h30 + i), i + 1, 0, 0));
    apply(mk(1, 1, 8'hAA, 16, 0, 0));
    for (int i = 0; i < 16; i++) apply(mk(0, 1, 8'h00, 15 - i, 0, 0));
    apply(mk(1, 1, 8'h55, 1, 0, 1));
    apply(mk(0, 1, 8'h00, 0, 0, 0));
    for (int i = 0; i < 10; i++) apply(mk(1, 0, 8'(8'h40 + i), i + 1, 0, 0));
    for (int i = 0; i < 10; i++) apply(mk(0, 1, 8'h00, 9 - i, 0, 0));
    for (int i = 0; i < 16; i++) apply(mk(1, 0, 8'(8'h20 + i), i + 1, 0, 0));
    for (int i = 0; i < 16; i++) apply(mk(0, 1, 8'h00, 15 - i, 0, 0));
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 8'(8'h60 + i), i + 1, 0, 0));
    @(negedge clk);
    reset = 0;
    #1;
    chk("async_rst_empty", 32'(empty), 1);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_r_data", 32'(r_data), 0);
    sb.delete();
    exp_r = 0;
    @(negedge clk);
    reset = 1;
    apply(mk(0, 0, 8'h00, 0, 0, 0));
    apply(mk(1, 0, 8'h5A, 1, 0, 0));
    apply(mk(0, 0, 8'h00, 1, 0, 0));
    apply(mk(0, 1, 8'h00, 0, 0, 0));
    chk("last_word", 32'(r_data), 32'h5A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
